reg_file_shift: RTL and testbench

Parametrised general-purpose register file: NUM_REGS x DATA_W, one write port and two read ports with registered outputs and write-to-read bypass. Adds an in-place multi-cycle shift/rotate engine that operates directly on any selected register. It sits between the datapath ALU and the register write-back path, so shift instructions do not consume ALU cycles.

---
 rtl/reg_file_shift_pkg.sv | 5 +
 rtl/reg_file_shift_step.sv | 15 +
 rtl/reg_file_shift.sv | 99 +++++++++
 tb/tb_reg_file_shift.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/reg_file_shift_pkg.sv
// reg_file_pkg: shared shift-op encodings and FSM states for reg_file_shift
package reg_file_pkg;
   typedef enum logic [1:0] {SH_LSL = 2'b00, SH_LSR = 2'b01, SH_ASR = 2'b10, SH_ROR = 2'b11} sh_op_t;
   typedef enum logic {ST_IDLE = 1'b0, ST_SHIFT = 1'b1} state_t;
endpackage

// File: rtl/reg_file_shift_step.sv
// rf_shift_step: combinational 1-bit shift/rotate of one word
module rf_shift_step
   import reg_file_pkg::*;
#(
   parameter int DATA_W = 16
) (
   input  logic [DATA_W-1:0] i_word,
   input  sh_op_t            i_op,
   output logic [DATA_W-1:0] o_word
);
   assign o_word = i_op == SH_LSL ? {i_word[DATA_W-2:0], 1'b0} :
                   i_op == SH_LSR ? {1'b0, i_word[DATA_W-1:1]} :
                   i_op == SH_ASR ? {i_word[DATA_W-1], i_word[DATA_W-1:1]} :
                                    {i_word[0], i_word[DATA_W-1:1]};
endmodule

// File: rtl/reg_file_shift.sv
// reg_file_shift: register file with bypassed registered reads and an in-place multi-cycle shifter
module reg_file_shift
   import reg_file_pkg::*;
#(
   parameter int DATA_W   = 16,
   parameter int NUM_REGS = 8,
   parameter int ZERO_R0  = 0,
   localparam int ADDR_W  = $clog2(NUM_REGS),
   localparam int AMT_W   = $clog2(DATA_W)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              wr,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] d,
   input  logic [ADDR_W-1:0] rd_addr_a,
   input  logic [ADDR_W-1:0] rd_addr_b,
   output logic [DATA_W-1:0] d_out_a,
   output logic [DATA_W-1:0] d_out_b,
   input  logic              sh_start,
   input  logic [ADDR_W-1:0] sh_addr,
   input  logic [1:0]        sh_op,
   input  logic [AMT_W-1:0]  sh_amt,
   output logic              sh_busy,
   output logic              sh_done,
   output logic              sh_abort
);
   logic [DATA_W-1:0] r_regs [NUM_REGS];
   logic [DATA_W-1:0] w_next [NUM_REGS];
   state_t            r_state;
   logic [ADDR_W-1:0] r_addr;
   sh_op_t            r_op;
   logic [AMT_W-1:0]  r_cnt;
   logic [DATA_W-1:0] w_cur, w_step, w_rd_a, w_rd_b;
   logic              w_hit, w_tgt_ok;

   assign w_hit    = wr && wr_addr == r_addr;
   assign w_tgt_ok = int'(sh_addr) < NUM_REGS && !(ZERO_R0 != 0 && sh_addr == '0);

   rf_shift_step #(.DATA_W(DATA_W)) u_step (.i_word(w_cur), .i_op(r_op), .o_word(w_step));

   always_comb begin
      w_cur = '0;
      for (int i = 0; i < NUM_REGS; i++)
         w_cur = r_addr == ADDR_W'(i) ? r_regs[i] : w_cur;
   end

   // Post-edge register image: a write overrides a shift step, and reads bypass from it.
   always_comb begin
      w_rd_a = '0;
      w_rd_b = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         w_next[i] = (ZERO_R0 != 0 && i == 0)                     ? '0 :
                     (wr && wr_addr == ADDR_W'(i))                 ? d :
                     (r_state == ST_SHIFT && r_addr == ADDR_W'(i)) ? w_step : r_regs[i];
         w_rd_a = rd_addr_a == ADDR_W'(i) ? w_next[i] : w_rd_a;
         w_rd_b = rd_addr_b == ADDR_W'(i) ? w_next[i] : w_rd_b;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_regs   <= '{default: '0};
         d_out_a  <= '0;
         d_out_b  <= '0;
         r_state  <= ST_IDLE;
         r_addr   <= '0;
         r_op     <= SH_LSL;
         r_cnt    <= '0;
         sh_busy  <= 1'b0;
         sh_done  <= 1'b0;
         sh_abort <= 1'b0;
      end else begin
         r_regs   <= w_next;
         d_out_a  <= w_rd_a;
         d_out_b  <= w_rd_b;
         sh_done  <= 1'b0;
         sh_abort <= 1'b0;
         if (r_state == ST_IDLE) begin
            if (sh_start) begin
               r_addr <= sh_addr;
               r_op   <= sh_op_t'(sh_op);
               r_cnt  <= sh_amt;
               if (sh_amt != '0 && w_tgt_ok) begin
                  r_state <= ST_SHIFT;
                  sh_busy <= 1'b1;
               end else
                  sh_done <= 1'b1;
            end
         end else if (w_hit || r_cnt == AMT_W'(1)) begin
            r_state  <= ST_IDLE;
            sh_busy  <= 1'b0;
            sh_abort <= w_hit;
            sh_done  <= !w_hit;
         end else
            r_cnt <= r_cnt - AMT_W'(1);
      end
   end
endmodule

// File: tb/tb_reg_file_shift.sv
// tb_reg_file_shift: random and directed checks of two reg_file_shift builds against a word-level model
module tb_reg_file_shift;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset = 1'b1, wr = 1'b0, sh_start = 1'b0;
   logic [2:0]  wr_addr = '0, rd_addr_a = '0, rd_addr_b = '0, sh_addr = '0;
   logic [15:0] d = '0;
   logic [1:0]  sh_op = '0;
   logic [3:0]  sh_amt = '0;
   logic [15:0] da [2];
   logic [15:0] db [2];
   logic        busy [2];
   logic        done [2];
   logic        abrt [2];

   int n_chk = 0, n_err = 0;

   reg_file_shift #(.DATA_W(16), .NUM_REGS(8), .ZERO_R0(0)) dut (
      .clk(clk), .reset(reset), .wr(wr), .wr_addr(wr_addr), .d(d),
      .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .d_out_a(da[0]), .d_out_b(db[0]),
      .sh_start(sh_start), .sh_addr(sh_addr), .sh_op(sh_op), .sh_amt(sh_amt),
      .sh_busy(busy[0]), .sh_done(done[0]), .sh_abort(abrt[0]));

   reg_file_shift #(.DATA_W(16), .NUM_REGS(6), .ZERO_R0(1)) dut_z (
      .clk(clk), .reset(reset), .wr(wr), .wr_addr(wr_addr), .d(d),
      .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .d_out_a(da[1]), .d_out_b(db[1]),
      .sh_start(sh_start), .sh_addr(sh_addr), .sh_op(sh_op), .sh_amt(sh_amt),
      .sh_busy(busy[1]), .sh_done(done[1]), .sh_abort(abrt[1]));

   logic [15:0] mem [2][8];
   logic [15:0] m_orig [2];
   logic [15:0] m_a [2];
   logic [15:0] m_b [2];
   bit          m_busy [2];
   bit          m_done [2];
   bit          m_abort [2];
   int          m_tgt [2];
   int          m_op [2];
   int          m_n [2];
   int          m_k [2];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Value of a word after k single-bit steps, computed in one go.
   function automatic logic [15:0] shifted(input logic [15:0] v, input int op, input int k);
      case (op)
         0:       return v << k;
         1:       return v >> k;
         2:       return 16'($signed(v) >>> k);
         default: return k == 0 ? v : (v >> k) | (v << (16 - k));
      endcase
   endfunction

   task automatic model(input int c, input int nr, input bit zr);
      logic [15:0] nm [8];
      bit arm;
      arm = 0;
      if (reset) begin
         for (int i = 0; i < 8; i++) mem[c][i] = '0;
         m_busy[c] = 0; m_done[c] = 0; m_abort[c] = 0; m_a[c] = '0; m_b[c] = '0;
         return;
      end
      nm = mem[c];
      m_done[c] = 0;
      m_abort[c] = 0;
      if (m_busy[c]) begin
         if (wr && int'(wr_addr) == m_tgt[c]) begin
            m_abort[c] = 1; m_busy[c] = 0;
         end else begin
            m_k[c]++;
            nm[m_tgt[c]] = shifted(m_orig[c], m_op[c], m_k[c]);
            if (m_k[c] == m_n[c]) begin m_busy[c] = 0; m_done[c] = 1; end
         end
      end else if (sh_start) begin
         if (sh_amt == 0 || int'(sh_addr) >= nr || (zr && sh_addr == 0)) m_done[c] = 1;
         else begin
            m_busy[c] = 1; m_tgt[c] = int'(sh_addr); m_op[c] = int'(sh_op);
            m_n[c] = int'(sh_amt); m_k[c] = 0; arm = 1;
         end
      end
      if (wr && int'(wr_addr) < nr && !(zr && wr_addr == 0)) nm[wr_addr] = d;
      if (arm) m_orig[c] = nm[m_tgt[c]];
      mem[c] = nm;
      m_a[c] = (int'(rd_addr_a) < nr && !(zr && rd_addr_a == 0)) ? nm[rd_addr_a] : '0;
      m_b[c] = (int'(rd_addr_b) < nr && !(zr && rd_addr_b == 0)) ? nm[rd_addr_b] : '0;
   endtask

   task automatic cycle();
      model(0, 8, 0);
      model(1, 6, 1);
      @(posedge clk);
      #1;
      for (int c = 0; c < 2; c++) begin
         chk($sformatf("c%0d d_out_a", c), da[c], m_a[c]);
         chk($sformatf("c%0d d_out_b", c), db[c], m_b[c]);
         chk($sformatf("c%0d sh_busy", c), busy[c], m_busy[c]);
         chk($sformatf("c%0d sh_done", c), done[c], m_done[c]);
         chk($sformatf("c%0d sh_abort", c), abrt[c], m_abort[c]);
      end
   endtask

   task automatic write(input logic [2:0] a, input logic [15:0] v);
      wr = 1'b1; wr_addr = a; d = v;
      cycle();
      wr = 1'b0;
   endtask

   task automatic run_shift(input logic [2:0] a, input logic [1:0] op, input logic [3:0] amt, output int nb);
      int t;
      nb = 0;
      t = 0;
      sh_start = 1'b1; sh_addr = a; sh_op = op; sh_amt = amt;
      cycle();
      sh_start = 1'b0;
      while (!done[0] && !abrt[0] && t < 64) begin
         if (busy[0]) nb++;
         cycle();
         t++;
      end
      chk("shift ends", 32'(t < 64), 1);
   endtask

   initial begin
      int nb;
      cycle();
      cycle();
      reset = 1'b0;
      chk("reset d_out_a", da[0], 0);
      chk("reset sh_busy", busy[0], 0);
      write(3'd3, 16'hA5A5);
      rd_addr_a = 3'd3;
      cycle();
      chk("read r3", da[0], 16'hA5A5);
      wr = 1'b1; wr_addr = 3'd5; d = 16'h1234; rd_addr_b = 3'd5;
      cycle();
      wr = 1'b0;
      chk("bypass r5", db[0], 16'h1234);

      write(3'd2, 16'h00F1);
      run_shift(3'd2, 2'b00, 4'd3, nb);
      chk("lsl busy cycles", nb, 3);
      chk("lsl done", done[0], 1);
      rd_addr_a = 3'd2;
      cycle();
      chk("lsl result", da[0], 16'h0788);
      run_shift(3'd5, 2'b11, 4'd4, nb);
      rd_addr_a = 3'd5;
      cycle();
      chk("ror result", da[0], 16'h4123);

      write(3'd1, 16'h8000);
      run_shift(3'd1, 2'b10, 4'd15, nb);
      chk("asr busy cycles", nb, 15);
      rd_addr_a = 3'd1;
      cycle();
      chk("asr result", da[0], 16'hFFFF);
      run_shift(3'd1, 2'b01, 4'd0, nb);
      chk("amt0 busy cycles", nb, 0);
      chk("amt0 done", done[0], 1);
      cycle();
      chk("amt0 unchanged", da[0], 16'hFFFF);

      write(3'd4, 16'h0001);
      sh_start = 1'b1; sh_addr = 3'd4; sh_op = 2'b00; sh_amt = 4'd8;
      cycle();
      sh_start = 1'b0;
      cycle();
      cycle();
      rd_addr_a = 3'd4;
      write(3'd4, 16'hBEEF);
      chk("abort pulse", abrt[0], 1);
      chk("abort no done", done[0], 0);
      chk("abort value", da[0], 16'hBEEF);
      sh_start = 1'b1;
      cycle();
      sh_start = 1'b0;
      cycle();
      cycle();
      reset = 1'b1;
      cycle();
      reset = 1'b0;
      chk("mid-shift reset busy", busy[0], 0);
      chk("mid-shift reset data", da[0], 0);
      for (int i = 0; i < 5; i++) cycle();

      write(3'd0, 16'hFFFF);
      write(3'd7, 16'hFFFF);
      rd_addr_a = 3'd0; rd_addr_b = 3'd7;
      cycle();
      chk("zr r0 read", da[1], 0);
      chk("zr addr7 read", db[1], 0);
      chk("full r7 read", db[0], 16'hFFFF);
      sh_start = 1'b1; sh_addr = 3'd0; sh_op = 2'b00; sh_amt = 4'd5;
      cycle();
      sh_start = 1'b0;
      chk("zr r0 shift done", done[1], 1);
      chk("zr r0 shift busy", busy[1], 0);
      for (int i = 0; i < 8; i++) cycle();

      for (int i = 0; i < 3000; i++) begin
         reset     = $urandom_range(0, 299) == 0;
         wr        = $urandom_range(0, 3) == 0;
         wr_addr   = 3'($urandom);
         d         = 16'($urandom);
         rd_addr_a = 3'($urandom);
         rd_addr_b = 3'($urandom);
         sh_start  = $urandom_range(0, 5) == 0;
         sh_addr   = 3'($urandom);
         sh_op     = 2'($urandom);
         sh_amt    = 4'($urandom);
         cycle();
      end
      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule
